// File: rtl/konark_tohost_monitor.sv
// ---------------------------------------------------------------------------
// konark_tohost_monitor
//
// Passive snooper for the Konark test harness. Watches the cluster memory
// request stream for writes to the `tohost` mailbox word and turns them into
// a sticky exit status or a pending syscall pointer for the host-side fesvr
// glue. An optional cycle-budget watchdog forces an exit when it expires.
// The snooped bus is never back-pressured; snoop_q_ready_i is only observed.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   snoop_q_*_i         snooped request (valid/ready/write/addr/data/strb)
//   exit_valid_o        sticky: program ended (exit commit or timeout)
//   exit_code_o         exit code, valid while exit_valid_o is high
//   syscall_valid_o     syscall pointer pending for the host
//   syscall_ptr_o       syscall argument pointer
//   syscall_ready_i     host accepts the pending syscall
//   overflow_o          sticky: a syscall commit was dropped
//   timeout_o           sticky: the watchdog expired
//   cycles_o            cycles since reset, frozen once the program ends
// ---------------------------------------------------------------------------
module konark_tohost_monitor #(
  parameter int unsigned             AddrWidth     = 48,
  parameter int unsigned             DataWidth     = 64,
  parameter logic [AddrWidth-1:0]    ToHostAddr    = 48'h8000_1000,
  parameter int unsigned             CodeWidth     = 32,
  parameter longint unsigned         TimeoutCycles = 0,
  localparam int unsigned            StrbWidth     = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 snoop_q_valid_i,
  input  logic                 snoop_q_ready_i,
  input  logic                 snoop_q_write_i,
  input  logic [AddrWidth-1:0] snoop_q_addr_i,
  input  logic [DataWidth-1:0] snoop_q_data_i,
  input  logic [StrbWidth-1:0] snoop_q_strb_i,
  output logic                 exit_valid_o,
  output logic [CodeWidth-1:0] exit_code_o,
  output logic                 syscall_valid_o,
  output logic [DataWidth-1:0] syscall_ptr_o,
  input  logic                 syscall_ready_i,
  output logic                 overflow_o,
  output logic                 timeout_o,
  output logic [63:0]          cycles_o
);

  localparam int unsigned OffBits  = $clog2(StrbWidth);
  localparam logic [63:0] ExpireAt = 64'(TimeoutCycles) - 64'd1;

  typedef enum logic [1:0] {
    IDLE,
    SYSCALL,
    EXITED,
    TIMEOUT
  } state_e;

  state_e               state_q;
  logic [DataWidth-1:0] shadow_q;
  logic [DataWidth-1:0] merged;
  logic                 terminal;
  logic                 hit;
  logic                 commit;
  logic                 is_exit;
  logic                 is_syscall;
  logic                 expire;

  // Byte-offset address bits select a byte within the mailbox word and are
  // deliberately ignored when matching.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^snoop_q_addr_i[OffBits-1:0];

  assign terminal = (state_q == EXITED) || (state_q == TIMEOUT);

  // Once the program has ended every further mailbox write is ignored,
  // including the shadow merge.
  assign hit = snoop_q_valid_i && snoop_q_ready_i && snoop_q_write_i && !terminal &&
               (snoop_q_addr_i[AddrWidth-1:OffBits] == ToHostAddr[AddrWidth-1:OffBits]);

  // Shadow with this beat's strobed bytes applied; a write touching the top
  // byte commits, which lets software store low half first, then high half.
  // NOTE: every always_comb output is given a default before any branch so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    merged = shadow_q;
    for (int b = 0; b < int'(StrbWidth); b++) begin
      if (snoop_q_strb_i[b]) merged[b*8 +: 8] = snoop_q_data_i[b*8 +: 8];
    end
  end

  assign commit     = hit && snoop_q_strb_i[StrbWidth-1];
  assign is_exit    = commit && merged[0];
  assign is_syscall = commit && !merged[0] && (merged != '0);
  assign expire     = (TimeoutCycles != 0) && !terminal && (cycles_o == ExpireAt);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      shadow_q        <= '0;
      exit_valid_o    <= 1'b0;
      exit_code_o     <= '0;
      syscall_valid_o <= 1'b0;
      syscall_ptr_o   <= '0;
      overflow_o      <= 1'b0;
      timeout_o       <= 1'b0;
      cycles_o        <= '0;
    end else begin
      if (hit) shadow_q <= commit ? '0 : merged;

      // The counter freezes on the very edge the terminal state is entered.
      if (!terminal && !is_exit && !expire && (cycles_o != '1)) begin
        cycles_o <= cycles_o + 64'd1;
      end

      case (state_q)
        IDLE, SYSCALL: begin
          if (is_exit) begin
            // An exit commit beats a same-cycle watchdog expiry and drops
            // any pending syscall.
            state_q         <= EXITED;
            exit_valid_o    <= 1'b1;
            exit_code_o     <= merged[CodeWidth:1];
            syscall_valid_o <= 1'b0;
          end else if (expire) begin
            state_q         <= TIMEOUT;
            exit_valid_o    <= 1'b1;
            exit_code_o     <= '1;
            timeout_o       <= 1'b1;
            syscall_valid_o <= 1'b0;
          end else if (state_q == IDLE) begin
            if (is_syscall) begin
              state_q         <= SYSCALL;
              syscall_valid_o <= 1'b1;
              syscall_ptr_o   <= merged;
            end
          end else begin
            // Only one syscall can be outstanding; a second one, even in the
            // acceptance cycle, is dropped and the pointer stays put.
            if (is_syscall) overflow_o <= 1'b1;
            if (syscall_ready_i) begin
              state_q         <= IDLE;
              syscall_valid_o <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
